mealy_dual_pattern_detector: RTL

- Parametrised Mealy sequence detector for a serial bit stream. It flags when the most recent PAT_LEN bits, including the current input, equal either of two programmable patterns.
- Generalises the fixed 3-bit "010 or 101" detector:
  - configurable pattern length and patterns;
  - overlapping or non-overlapping match mode;
  - input qualifier (`en`) and synchronous clear (`clr`);
  - per-pattern hit flags and a saturating match counter.
- Sits behind a serial receiver as a frame/marker detector.

---
 rtl/mealy_dual_pattern_detector.sv | 118 +++++++++++
 1 files changed

// File: rtl/mealy_dual_pattern_detector.sv
// Mealy sequence detector for a serial bit stream.
// The window is the last PAT_LEN-1 consumed bits plus the bit currently on x.
// A hit is flagged in the same cycle as the completing bit when that window
// equals PAT_A or PAT_B. Overlapping and non-overlapping matching are both
// supported. A saturating counter records the number of matches.
module mealy_dual_pattern_detector #(
    parameter int                 PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PAT_A   = 3'b101,
    parameter logic [PAT_LEN-1:0] PAT_B   = 3'b010,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             en,
    input  logic             clr,
    output logic             y,
    output logic             hit_a,
    output logic             hit_b,
    output logic [CNT_W-1:0] match_cnt
);

    // fill counts 0..PAT_LEN-1, so PAT_LEN distinct values
    localparam int                FILL_W   = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);
    localparam logic [FILL_W-1:0] FILL_ONE = FILL_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    // FILLING: history not yet long enough to match; ARMED: matching active
    typedef enum logic {
        FILLING = 1'b0,
        ARMED   = 1'b1
    } phase_t;

    logic [PAT_LEN-2:0] hist_r;
    logic [FILL_W-1:0]  fill_r;
    phase_t             phase_r;
    logic [CNT_W-1:0]   cnt_r;

    logic [PAT_LEN-1:0] win_s;
    logic               armed_s;
    logic               hit_a_s;
    logic               hit_b_s;
    logic               match_s;
    logic [FILL_W-1:0]  fill_inc_s;

    // Saturating increment: holds at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    // Mealy window compare; en gates everything so an unknown x with en=0 stays out of the outputs
    always_comb begin
        win_s      = {hist_r, x};
        fill_inc_s = fill_r + FILL_ONE;
        case (phase_r)
            ARMED:   armed_s = 1'b1;
            FILLING: armed_s = 1'b0;
            default: armed_s = 1'b0;
        endcase
        hit_a_s = en & armed_s & (win_s == PAT_A);
        hit_b_s = en & armed_s & (win_s == PAT_B);
        match_s = hit_a_s | hit_b_s;
    end

    assign hit_a     = hit_a_s;
    assign hit_b     = hit_b_s;
    assign y         = match_s;
    assign match_cnt = cnt_r;

    // History shift, fill phase tracking and match counting (reset > clr > en > hold)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_r  <= {(PAT_LEN-1){1'b0}};
            fill_r  <= {FILL_W{1'b0}};
            phase_r <= FILLING;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (clr) begin
            hist_r  <= {(PAT_LEN-1){1'b0}};
            fill_r  <= {FILL_W{1'b0}};
            phase_r <= FILLING;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (en) begin
            // Shift is unconditional; after a non-overlapping match the
            // contents are don't-care because fill restarts from zero.
            hist_r <= win_s[PAT_LEN-2:0];
            if (match_s && (OVERLAP == 1'b0)) begin
                fill_r  <= {FILL_W{1'b0}};
                phase_r <= FILLING;
            end else if (fill_r == FILL_MAX) begin
                fill_r  <= fill_r;
                phase_r <= ARMED;
            end else begin
                fill_r  <= fill_inc_s;
                phase_r <= (fill_inc_s == FILL_MAX) ? ARMED : FILLING;
            end
            if (match_s) begin
                cnt_r <= sat_inc(cnt_r);
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            hist_r  <= hist_r;
            fill_r  <= fill_r;
            phase_r <= phase_r;
            cnt_r   <= cnt_r;
        end
    end

endmodule
